// File: rtl/interrupt_ctrl_pkg.sv
// Shared constants for the interrupt controller: source bit indices,
// default register addresses and the default number of implemented sources.
package interrupt_ctrl_pkg;

  localparam int unsigned IRQ_VBLANK = 0;
  localparam int unsigned IRQ_STAT   = 1;
  localparam int unsigned IRQ_TIMER  = 2;
  localparam int unsigned IRQ_SERIAL = 3;
  localparam int unsigned IRQ_JOYPAD = 4;

  localparam logic [15:0] IF_ADDR_DEF = 16'hFF0F;
  localparam logic [15:0] IE_ADDR_DEF = 16'hFFFF;
  localparam int unsigned NUM_IRQ_DEF = 5;

endpackage

// File: rtl/irq_edge_det.sv
// Per-bit rising-edge detector. Reset loads the current level so a source
// already high when reset is released does not produce an edge.
module irq_edge_det #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] level_i,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] prev_d;

  // Next previous-level value and rising-edge decode
  always_comb begin
    prev_d = level_i;
    rise_o = level_i & ~prev_q;
  end

  // Previous-level register
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= level_i;
    end else begin
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/interrupt_ctrl.sv
// Interrupt flag / enable register pair with CPU read-write access,
// edge-triggered source capture and per-vector acknowledge.
module interrupt_ctrl
  import interrupt_ctrl_pkg::*;
#(
  parameter logic [15:0] IF_ADDR = IF_ADDR_DEF,
  parameter logic [15:0] IE_ADDR = IE_ADDR_DEF,
  parameter int unsigned NUM_IRQ = NUM_IRQ_DEF
) (
  input  logic               CLK,
  input  logic               SYNC_RES,
  input  logic [15:0]        A,
  input  logic [7:0]         DIN,
  input  logic               WR,
  input  logic               RD,
  output logic [7:0]         DOUT,
  output logic               DOUT_OE,
  input  logic [NUM_IRQ-1:0] INT_REQ,
  input  logic [7:0]         CPU_IRQ_ACK,
  output logic [7:0]         CPU_IRQ_TRIG,
  output logic               IRQ_ANY
);

  logic [NUM_IRQ-1:0] edge_s;
  logic [NUM_IRQ-1:0] if_q, if_d, if_base_s;
  logic [7:0]         ie_q, ie_d;
  logic [7:0]         dout_q, dout_d;
  logic               dout_oe_q, dout_oe_d;
  logic               wr_if_s, wr_ie_s, rd_if_s, rd_ie_s;
  logic [7:0]         if_rd_val_s;
  logic [7:0]         trig_s;

  irq_edge_det #(.WIDTH(NUM_IRQ)) u_edge_det (
    .clk     (CLK),
    .rst     (SYNC_RES),
    .level_i (INT_REQ),
    .rise_o  (edge_s)
  );

  // Register next-state: a new edge beats an acknowledge, which beats a write
  always_comb begin
    wr_if_s = WR & (A == IF_ADDR);
    wr_ie_s = WR & (A == IE_ADDR);
    rd_if_s = RD & (A == IF_ADDR);
    rd_ie_s = RD & (A == IE_ADDR);

    if (wr_if_s) begin
      if_base_s = DIN[NUM_IRQ-1:0];
    end else begin
      if_base_s = if_q;
    end
    if_d = (if_base_s & ~CPU_IRQ_ACK[NUM_IRQ-1:0]) | edge_s;

    if (wr_ie_s) begin
      ie_d = DIN;
    end else begin
      ie_d = ie_q;
    end

    // Unimplemented flag bits read back as ones
    if_rd_val_s = 8'hFF;
    if_rd_val_s[NUM_IRQ-1:0] = if_q;

    if (rd_if_s) begin
      dout_d    = if_rd_val_s;
      dout_oe_d = 1'b1;
    end else if (rd_ie_s) begin
      dout_d    = ie_q;
      dout_oe_d = 1'b1;
    end else begin
      dout_d    = dout_q;
      dout_oe_d = 1'b0;
    end
  end

  // Pending-and-enabled vector, driven straight from the registers
  always_comb begin
    trig_s = 8'h00;
    trig_s[NUM_IRQ-1:0] = if_q & ie_q[NUM_IRQ-1:0];
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (SYNC_RES) begin
      if_q      <= '0;
      ie_q      <= 8'h00;
      dout_q    <= 8'h00;
      dout_oe_q <= 1'b0;
    end else begin
      if_q      <= if_d;
      ie_q      <= ie_d;
      dout_q    <= dout_d;
      dout_oe_q <= dout_oe_d;
    end
  end

  assign DOUT         = dout_q;
  assign DOUT_OE      = dout_oe_q;
  assign CPU_IRQ_TRIG = trig_s;
  assign IRQ_ANY      = |trig_s;

endmodule
